module_uart_rx: RTL and testbench
=================================

MODULE_UART_RX -- requirements
Module: module_uart_rx

Interface
REQ-001 The block SHALL expose parameter CLK_FREQ, default 10_000_000, system clock frequency in Hz.
REQ-002 The block SHALL expose parameter BAUD, default 9600, serial bit rate.
REQ-003 The block SHALL derive DIV = CLK_FREQ / (BAUD*16), truncated, as the 16x oversample divisor; DIV < 2 SHALL be a parameter error.
REQ-004 The block SHALL have exactly one clock and one reset; reset is asynchronous and active-low.
REQ-005 clk_i  input  1  system clock (10 MHz domain), all logic on rising edge.
REQ-006 rst_i  input  1  asynchronous, active-low reset.
REQ-007 rx_i  input  1  asynchronous serial line; idle high; 8N1, LSB first.
REQ-008 ack_i  input  1  consumer acknowledge of the current byte.
REQ-009 data_o  output  8  last received byte.
REQ-010 valid_o  output  1  data_o holds an unacknowledged byte.
REQ-011 frame_err_o  output  1  one-cycle pulse, stop bit sampled low.
REQ-012 overrun_o  output  1  one-cycle pulse, byte lost because valid_o was still high.
REQ-013 busy_o  output  1  high whenever the FSM is not in IDLE.

Function
REQ-014 rx_i SHALL pass through a 2-FF synchronizer (both FFs reset to 1); the FSM uses only the synchronized value rxs.
REQ-015 A tick counter SHALL run 0..DIV-1 and produce a one-cycle tick at DIV-1; it SHALL clear on every transition out of IDLE.
REQ-016 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-017 IDLE -> START on a falling edge of rxs (previous 1, current 0); a line held low SHALL NOT retrigger.
REQ-018 START: at the 8th tick (mid start bit), rxs = 0 -> DATA with bit index 0; rxs = 1 -> IDLE, glitch rejected, no output activity.
REQ-019 DATA: every 16th tick SHALL sample rxs into bit[index], LSB first; after index 7 -> STOP.
REQ-020 STOP: at the 16th tick, rxs = 1 -> byte accepted, then IDLE; rxs = 0 -> frame_err_o pulses for 1 cycle, byte discarded, data_o/valid_o unchanged, then IDLE.
REQ-021 Byte acceptance SHALL register data_o and set valid_o on the clock edge following the stop-bit sample tick, i.e. 152*DIV +1 cycles after the first cycle rxs reads 0.
REQ-022 valid_o SHALL stay high until a cycle with ack_i = 1, and SHALL be low the following cycle; ack_i with valid_o = 0 SHALL be ignored.
REQ-023 Acceptance while valid_o = 1 and ack_i = 0 SHALL pulse overrun_o for 1 cycle, keep the old data_o and drop the new byte.
REQ-024 Acceptance in the same cycle as ack_i = 1 SHALL load the new byte, keep valid_o = 1 and not pulse overrun_o.
REQ-025 frame_err_o and overrun_o SHALL never be high for more than one consecutive cycle per event.

Reset
REQ-026 rst_i = 0 SHALL immediately force state IDLE, counters 0, shift register 0x00, data_o = 0x00, valid_o = 0, frame_err_o = 0, overrun_o = 0, busy_o = 0, synchronizer FFs = 1.
REQ-027 Reset during a frame SHALL abort it with no valid_o, frame_err_o or overrun_o; reception SHALL resume on the next falling edge after release.

Verification (CLK_FREQ = 1_600_000, BAUD = 10_000, DIV = 10, bit = 160 cycles)
REQ-028 Send 0x55 with a valid stop bit -> valid_o rises 1521 +/-2 cycles after rx_i falls, data_o = 0x55, frame_err_o = 0; ack_i for 1 cycle -> valid_o = 0 on the next cycle.
REQ-029 rx_i low for 40 cycles then high -> busy_o high then low within 80 cycles, valid_o and frame_err_o stay 0.
REQ-030 Send 0xA3 with stop bit 0 -> frame_err_o exactly one 1-cycle pulse, valid_o = 0, data_o unchanged (0x00 after reset).
REQ-031 Send 0x12 then 0x34 with no ack -> one overrun_o pulse, data_o = 0x12; then ack and send 0x56 -> data_o = 0x56, valid_o = 1, no overrun.
REQ-032 Assert rst_i low during data bit 4 of 0x9E -> all outputs 0 asynchronously; after release, send 0xC8 -> data_o = 0xC8, valid_o = 1.
REQ-033 Hold valid_o with 0x11 and pulse ack_i in the exact acceptance cycle of 0x22 -> data_o = 0x22, valid_o stays 1, overrun_o = 0.

Source files
------------

// File: rtl/module_uart_rx.sv
// 8N1 UART receiver with 16x oversampling, 2-FF line synchronizer and a
// single-entry output holding register with acknowledge/overrun handling.
module module_uart_rx #(
    parameter int CLK_FREQ = 10_000_000,
    parameter int BAUD     = 9600
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    input  logic       ack_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    output logic       frame_err_o,
    output logic       overrun_o,
    output logic       busy_o
);
    localparam int DATA_W = 8;
    localparam int IDX_W  = $clog2(DATA_W);
    localparam int DIV    = CLK_FREQ / (BAUD * 16);
    localparam int CNT_W  = (DIV < 2) ? 1 : $clog2(DIV);

    generate
        if (DIV < 2) begin : g_div_check
            $error("module_uart_rx: CLK_FREQ/(BAUD*16) must be at least 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nx;
    logic                rx_meta;
    logic                rxs;
    logic                rxs_d;
    logic [CNT_W-1:0]    div_cnt;
    logic                tick;
    logic [3:0]          tick_cnt;
    logic                tick_clr;
    logic [IDX_W-1:0]    bit_idx;
    logic [DATA_W-1:0]   shift_q;
    logic                sample_en;
    logic                accept;
    logic                frame_bad;

    // Line synchronizer; rxs_d is kept only to detect the start-bit falling edge
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            rxs_d   <= 1'b1;
        end else begin
            rx_meta <= rx_i;
            rxs     <= rx_meta;
            rxs_d   <= rxs;
        end
    end

    // Oversample divider, held at zero while idle so a frame always starts aligned
    assign tick = (div_cnt == CNT_W'(DIV - 1));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            div_cnt <= '0;
        end else if (state == IDLE || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        tick_clr  = 1'b0;
        sample_en = 1'b0;
        accept    = 1'b0;
        frame_bad = 1'b0;
        case (state)
            IDLE: begin
                if (rxs_d && !rxs) begin
                    state_nx = START;
                end
            end
            START: begin
                // Mid start bit: a line already back high was only a glitch
                if (tick && tick_cnt == 4'd7) begin
                    tick_clr = 1'b1;
                    state_nx = rxs ? IDLE : DATA;
                end
            end
            DATA: begin
                if (tick && tick_cnt == 4'd15) begin
                    sample_en = 1'b1;
                    if (bit_idx == IDX_W'(DATA_W - 1)) begin
                        state_nx = STOP;
                    end
                end
            end
            STOP: begin
                if (tick && tick_cnt == 4'd15) begin
                    state_nx  = IDLE;
                    accept    = rxs;
                    frame_bad = !rxs;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Tick and bit bookkeeping; the 4-bit tick count wraps every 16 ticks
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            tick_cnt <= '0;
            bit_idx  <= '0;
            shift_q  <= '0;
        end else begin
            if (state == IDLE || tick_clr) begin
                tick_cnt <= '0;
            end else if (tick) begin
                tick_cnt <= tick_cnt + 4'd1;
            end
            if (state == IDLE) begin
                bit_idx <= '0;
            end else if (sample_en) begin
                bit_idx <= bit_idx + IDX_W'(1);
            end
            if (sample_en) begin
                shift_q[bit_idx] <= rxs;
            end
        end
    end

    // Output holding register: an ack in the acceptance cycle frees the slot
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            data_o      <= '0;
            valid_o     <= 1'b0;
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
        end else begin
            frame_err_o <= frame_bad;
            overrun_o   <= accept && valid_o && !ack_i;
            if (accept && (!valid_o || ack_i)) begin
                data_o  <= shift_q;
                valid_o <= 1'b1;
            end else if (ack_i) begin
                valid_o <= 1'b0;
            end
        end
    end

    assign busy_o = (state != IDLE);

endmodule

// File: tb/tb_module_uart_rx.sv
// Self-checking bench for module_uart_rx at DIV = 10 (160 clocks per bit).
`timescale 1ns/1ps
module tb_module_uart_rx;
    localparam int CLK_FREQ = 1_600_000;
    localparam int BAUD     = 10_000;
    localparam int BIT_CYC  = 160;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       ack = 1'b0;
    logic [7:0] data_o;
    logic       valid_o;
    logic       frame_err_o;
    logic       overrun_o;
    logic       busy_o;

    module_uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
        .clk_i(clk), .rst_i(rst_n), .rx_i(rx), .ack_i(ack),
        .data_o(data_o), .valid_o(valid_o), .frame_err_o(frame_err_o),
        .overrun_o(overrun_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   ferr_hi = 0;
    int   ovr_hi = 0;
    int   vlow = 0;
    int   rise_cyc = -1;
    logic valid_q = 1'b0;
    logic watch = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (frame_err_o) ferr_hi <= ferr_hi + 1;
        if (overrun_o) ovr_hi <= ovr_hi + 1;
        if (watch && !valid_o) vlow <= vlow + 1;
        if (valid_o && !valid_q) rise_cyc <= cyc;
        valid_q <= valid_o;
    end

    int checks = 0;
    int errors = 0;
    int fall_cyc = 0;

    // Reference state: what the consumer should currently see
    logic [7:0] m_data = 8'h00;
    logic       m_valid = 1'b0;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       ack_first;
        logic [7:0] exp_data;
        logic       exp_valid;
        int         exp_ferr;
        int         exp_ovr;
    } vec_t;

    vec_t tbl [7];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic ack_pulse();
        @(posedge clk); #1 ack = 1'b1;
        @(posedge clk); #1 ack = 1'b0;
    endtask

    // Must be entered 1 time unit after a rising edge
    task automatic drive_frame(input logic [7:0] d, input logic stop);
        fall_cyc = cyc;
        rx = 1'b0;
        repeat (BIT_CYC) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1 rx = d[i];
            repeat (BIT_CYC) @(posedge clk);
        end
        #1 rx = stop;
        repeat (BIT_CYC) @(posedge clk);
        #1 rx = 1'b1;
        repeat (20) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        @(posedge clk); #1;
        drive_frame(d, stop);
    endtask

    // Frame outcome from the protocol rules, with an optional ack beforehand
    task automatic model_step(input logic [7:0] d, input logic stop, input logic ack_first,
                              output int e_ferr, output int e_ovr);
        e_ferr = 0;
        e_ovr  = 0;
        if (ack_first) m_valid = 1'b0;
        if (!stop) begin
            e_ferr = 1;
        end else if (m_valid) begin
            e_ovr = 1;
        end else begin
            m_data  = d;
            m_valid = 1'b1;
        end
    endtask

    task automatic run_frame(input logic [7:0] d, input logic stop, input logic ack_first,
                             output int ferr_d, output int ovr_d);
        int f0, o0;
        if (ack_first) ack_pulse();
        f0 = ferr_hi;
        o0 = ovr_hi;
        send_frame(d, stop);
        ferr_d = ferr_hi - f0;
        ovr_d  = ovr_hi - o0;
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int fd, od, ef, eo, f0, o0, n, lat;
        logic [7:0] rd;
        logic rs, ra;

        tbl[0] = '{8'hA3, 1'b0, 1'b0, 8'h00, 1'b0, 1, 0};
        tbl[1] = '{8'h55, 1'b1, 1'b0, 8'h55, 1'b1, 0, 0};
        tbl[2] = '{8'h12, 1'b1, 1'b1, 8'h12, 1'b1, 0, 0};
        tbl[3] = '{8'h34, 1'b1, 1'b0, 8'h12, 1'b1, 0, 1};
        tbl[4] = '{8'h56, 1'b1, 1'b1, 8'h56, 1'b1, 0, 0};
        tbl[5] = '{8'h77, 1'b0, 1'b0, 8'h56, 1'b1, 1, 0};
        tbl[6] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 0, 0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_data", data_o, 8'h00);
        check("reset_valid", valid_o, 0);
        check("reset_busy", busy_o, 0);
        check("reset_ferr", frame_err_o, 0);
        check("reset_ovr", overrun_o, 0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);

        // Short low glitch is rejected at mid start bit
        f0 = ferr_hi;
        @(posedge clk); #1 rx = 1'b0;
        repeat (10) @(posedge clk);
        #1 check("glitch_busy_set", busy_o, 1);
        repeat (30) @(posedge clk);
        #1 rx = 1'b1;
        n = 0;
        while (busy_o && n < 80) begin
            @(posedge clk); #1;
            n++;
        end
        check("glitch_busy_clear", busy_o, 0);
        check("glitch_valid", valid_o, 0);
        check("glitch_ferr", ferr_hi - f0, 0);
        repeat (20) @(posedge clk);

        // Table-driven frames
        for (int i = 0; i < 7; i++) begin
            run_frame(tbl[i].data, tbl[i].stop, tbl[i].ack_first, fd, od);
            check($sformatf("tbl%0d_data", i), data_o, tbl[i].exp_data);
            check($sformatf("tbl%0d_valid", i), valid_o, tbl[i].exp_valid);
            check($sformatf("tbl%0d_ferr", i), fd, tbl[i].exp_ferr);
            check($sformatf("tbl%0d_ovr", i), od, tbl[i].exp_ovr);
            m_data  = tbl[i].exp_data;
            m_valid = tbl[i].exp_valid;
        end

        // Acceptance latency, ack clears valid next cycle, stray ack ignored
        ack_pulse();
        check("ack_clears_valid", valid_o, 0);
        send_frame(8'h55, 1'b1);
        lat = rise_cyc - fall_cyc;
        checks++;
        if (lat < 1519 || lat > 1523) begin
            errors++;
            $display("FAIL latency: got %0d cycles, want 1521 +/- 2", lat);
        end
        check("lat_data", data_o, 8'h55);
        ack_pulse();
        check("ack_valid_low", valid_o, 0);
        ack_pulse();
        check("stray_ack_valid", valid_o, 0);
        check("stray_ack_data", data_o, 8'h55);
        m_data  = 8'h55;
        m_valid = 1'b0;

        // Randomized frames against the reference model
        for (int k = 0; k < 14; k++) begin
            rd = 8'($urandom);
            rs = ($urandom_range(0, 3) != 0);
            ra = 1'($urandom_range(0, 1));
            model_step(rd, rs, ra, ef, eo);
            run_frame(rd, rs, ra, fd, od);
            check($sformatf("rnd%0d_data", k), data_o, m_data);
            check($sformatf("rnd%0d_valid", k), valid_o, m_valid);
            check($sformatf("rnd%0d_ferr", k), fd, ef);
            check($sformatf("rnd%0d_ovr", k), od, eo);
        end

        // Ack lands in the exact acceptance cycle of the next byte
        model_step(8'h11, 1'b1, 1'b1, ef, eo);
        run_frame(8'h11, 1'b1, 1'b1, fd, od);
        check("hold_data", data_o, 8'h11);
        o0 = ovr_hi;
        n  = vlow;
        @(posedge clk); #1;
        watch = 1'b1;
        fork
            drive_frame(8'h22, 1'b1);
            begin
                repeat (1522) @(posedge clk);
                #1 ack = 1'b1;
                @(posedge clk);
                #1 ack = 1'b0;
            end
        join
        watch = 1'b0;
        check("same_cycle_data", data_o, 8'h22);
        check("same_cycle_valid", valid_o, 1);
        check("same_cycle_ovr", ovr_hi - o0, 0);
        check("same_cycle_valid_gap", vlow - n, 0);

        // Reset in the middle of data bit 4 aborts the frame
        f0 = ferr_hi;
        o0 = ovr_hi;
        @(posedge clk); #1;
        fork
            drive_frame(8'h9E, 1'b1);
            begin
                repeat (850) @(posedge clk);
                #3 rst_n = 1'b0;
                #1;
                check("midreset_data", data_o, 8'h00);
                check("midreset_valid", valid_o, 0);
                check("midreset_busy", busy_o, 0);
                repeat (450) @(posedge clk);
                #3 rst_n = 1'b1;
            end
        join
        check("abort_valid", valid_o, 0);
        check("abort_ferr", ferr_hi - f0, 0);
        check("abort_ovr", ovr_hi - o0, 0);
        m_data  = 8'h00;
        m_valid = 1'b0;
        model_step(8'hC8, 1'b1, 1'b0, ef, eo);
        run_frame(8'hC8, 1'b1, 1'b0, fd, od);
        check("resume_data", data_o, m_data);
        check("resume_valid", valid_o, m_valid);
        check("resume_ferr", fd, ef);
        check("resume_ovr", od, eo);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
